// File: rtl/decode_issue_stage_if.sv
// decode_issue_stage_if: fetch-side pair/pc/flush inputs, stall back-pressure,
// and the two issue-pipe outputs of the dual-issue decode stage.
// master = fetch/issue environment, slave = decode_issue_stage.
interface decode_issue_stage_if;
    logic [0:31] first_inst;
    logic [0:31] second_inst;
    logic [0:31] pc_in;
    logic        branch_taken;
    logic        stall;
    logic [0:31] even_inst;
    logic [0:31] odd_inst;
    logic        even_valid;
    logic        odd_valid;
    logic [0:31] even_pc;
    logic [0:31] odd_pc;
    logic [0:31] dual_count;

    modport master (
        output first_inst, second_inst, pc_in, branch_taken,
        input  stall, even_inst, odd_inst, even_valid, odd_valid,
               even_pc, odd_pc, dual_count
    );

    modport slave (
        input  first_inst, second_inst, pc_in, branch_taken,
        output stall, even_inst, odd_inst, even_valid, odd_valid,
               even_pc, odd_pc, dual_count
    );
endinterface

// File: rtl/decode_issue_stage.sv
// decode_issue_stage: dual-issue decode for an even/odd pipe pair.
// Each fetched pair is routed to the pipes in one cycle when compatible, or
// serialized over two cycles (PAIR -> HOLD -> PAIR) when both instructions
// need the same pipe. branch_taken flushes everything, including a held
// instruction. Optional build macro DECODE_DEP_CHECK_EN adds a RAW check
// (second RA/RB vs first RT) that also forces serialization.
package descriptions;
    localparam logic PIPE_EVEN = 1'b0;
    localparam logic PIPE_ODD  = 1'b1;

    localparam logic [0:10] ENOP_OPCODE = 11'b00000000001;
    localparam logic [0:10] ONOP_OPCODE = 11'b01000000001;

    // Pipe class from the opcode: quadword rotate/shift/load group (0011xxx...)
    // and the 01xxx... group (includes ONOP) go odd, everything else even.
    function automatic logic pipe_of(input logic [0:31] inst);
        logic [0:10] op;
        op = inst[0:10];
        if (op == ENOP_OPCODE)  return PIPE_EVEN;
        if (op == ONOP_OPCODE)  return PIPE_ODD;
        if (op[0:3] == 4'b0011) return PIPE_ODD;
        if (op[0:1] == 2'b01)   return PIPE_ODD;
        return PIPE_EVEN;
    endfunction

    function automatic logic is_nop(input logic [0:31] inst);
        return (inst[0:10] == ENOP_OPCODE) || (inst[0:10] == ONOP_OPCODE);
    endfunction
endpackage

module decode_issue_stage (
    input  logic                 clock,
    input  logic                 reset,
    decode_issue_stage_if.slave  bus
);
    import descriptions::*;

    localparam logic [0:0]  ST_PAIR   = 1'b0;
    localparam logic [0:0]  ST_HOLD   = 1'b1;
    localparam logic [0:31] ENOP_WORD = {ENOP_OPCODE, 21'b0};
    localparam logic [0:31] ONOP_WORD = {ONOP_OPCODE, 21'b0};

    // FSM and hold register
    logic [0:0]  state_q, state_d;
    logic [0:31] hold_inst_q, hold_inst_d;
    logic [0:31] hold_pc_q, hold_pc_d;

    // Registered issue outputs
    logic [0:31] even_inst_q, even_inst_d;
    logic [0:31] odd_inst_q, odd_inst_d;
    logic        even_valid_q, even_valid_d;
    logic        odd_valid_q, odd_valid_d;
    logic [0:31] even_pc_q, even_pc_d;
    logic [0:31] odd_pc_q, odd_pc_d;
    logic [0:31] dual_count_q, dual_count_d;

    // Per-slot decode of the incoming pair
    logic [0:31] slot_inst [2];
    logic [1:0]  slot_real;
    logic [1:0]  slot_odd;
    logic [0:31] pc_plus4;

    // Up to two instructions selected for issue this cycle
    logic [1:0]  cand_valid;
    logic [0:31] cand_inst [2];
    logic [0:31] cand_pc   [2];
    logic [1:0]  cand_odd;

    logic class_clash;
    logic dep_hit;
    logic conflict;

    assign slot_inst[0] = bus.first_inst;
    assign slot_inst[1] = bus.second_inst;
    assign pc_plus4     = bus.pc_in + 32'd4;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_slot
            assign slot_real[gi] = !is_nop(slot_inst[gi]);
            assign slot_odd[gi]  = pipe_of(slot_inst[gi]);
        end
    endgenerate

    assign class_clash = slot_real[0] && slot_real[1] && (slot_odd[0] == slot_odd[1]);

`ifdef DECODE_DEP_CHECK_EN
    // Second reads a register the first writes: cannot issue together.
    assign dep_hit = slot_real[0] && slot_real[1] &&
                     ((bus.second_inst[18:24] == bus.first_inst[25:31]) ||
                      (bus.second_inst[11:17] == bus.first_inst[25:31]));
`else
    assign dep_hit = 1'b0;
`endif

    assign conflict  = class_clash || dep_hit;

    // Fetch must replay the pair only when a conflicting pair is being split.
    assign bus.stall = !reset && !bus.branch_taken && (state_q == ST_PAIR) && conflict;

    // Choose what issues next edge and advance the PAIR/HOLD state.
    always_comb begin
        state_d     = state_q;
        hold_inst_d = hold_inst_q;
        hold_pc_d   = hold_pc_q;
        cand_valid  = 2'b00;
        cand_odd    = 2'b00;
        for (int i = 0; i < 2; i++) begin
            cand_inst[i] = 32'd0;
            cand_pc[i]   = 32'd0;
        end

        if (bus.branch_taken) begin
            state_d     = ST_PAIR;
            hold_inst_d = 32'd0;
            hold_pc_d   = 32'd0;
        end else if (state_q == ST_HOLD) begin
            cand_valid[0] = 1'b1;
            cand_inst[0]  = hold_inst_q;
            cand_pc[0]    = hold_pc_q;
            cand_odd[0]   = pipe_of(hold_inst_q);
            state_d       = ST_PAIR;
            hold_inst_d   = 32'd0;
            hold_pc_d     = 32'd0;
        end else begin
            if (slot_real[0]) begin
                cand_valid[0] = 1'b1;
                cand_inst[0]  = bus.first_inst;
                cand_pc[0]    = bus.pc_in;
                cand_odd[0]   = slot_odd[0];
            end
            if (conflict) begin
                state_d     = ST_HOLD;
                hold_inst_d = bus.second_inst;
                hold_pc_d   = pc_plus4;
            end else if (slot_real[1]) begin
                cand_valid[1] = 1'b1;
                cand_inst[1]  = bus.second_inst;
                cand_pc[1]    = pc_plus4;
                cand_odd[1]   = slot_odd[1];
            end
        end
    end

    // Steer each candidate to its pipe; an empty pipe gets its canonical NOP.
    always_comb begin
        even_inst_d  = ENOP_WORD;
        even_valid_d = 1'b0;
        even_pc_d    = 32'd0;
        odd_inst_d   = ONOP_WORD;
        odd_valid_d  = 1'b0;
        odd_pc_d     = 32'd0;
        for (int i = 0; i < 2; i++) begin
            if (cand_valid[i]) begin
                if (cand_odd[i]) begin
                    odd_inst_d  = cand_inst[i];
                    odd_valid_d = 1'b1;
                    odd_pc_d    = cand_pc[i];
                end else begin
                    even_inst_d  = cand_inst[i];
                    even_valid_d = 1'b1;
                    even_pc_d    = cand_pc[i];
                end
            end
        end
        dual_count_d = dual_count_q + {31'd0, even_valid_d & odd_valid_d};
    end

    // State, hold register and issue registers; reset drops any held instruction.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_PAIR;
            hold_inst_q  <= 32'd0;
            hold_pc_q    <= 32'd0;
            even_inst_q  <= ENOP_WORD;
            odd_inst_q   <= ONOP_WORD;
            even_valid_q <= 1'b0;
            odd_valid_q  <= 1'b0;
            even_pc_q    <= 32'd0;
            odd_pc_q     <= 32'd0;
            dual_count_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            hold_inst_q  <= hold_inst_d;
            hold_pc_q    <= hold_pc_d;
            even_inst_q  <= even_inst_d;
            odd_inst_q   <= odd_inst_d;
            even_valid_q <= even_valid_d;
            odd_valid_q  <= odd_valid_d;
            even_pc_q    <= even_pc_d;
            odd_pc_q     <= odd_pc_d;
            dual_count_q <= dual_count_d;
        end
    end

    assign bus.even_inst  = even_inst_q;
    assign bus.odd_inst   = odd_inst_q;
    assign bus.even_valid = even_valid_q;
    assign bus.odd_valid  = odd_valid_q;
    assign bus.even_pc    = even_pc_q;
    assign bus.odd_pc     = odd_pc_q;
    assign bus.dual_count = dual_count_q;
endmodule

// File: doc/decode_issue_stage.md
DECODE_ISSUE_STAGE -- requirements
Module: decode_issue_stage

Interface
REQ-001 SHALL have port clock, input, 1 bit: rising-edge clock for all state.
REQ-002 SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-003 SHALL have port first_inst, input, [0:31]: even-slot instruction from fetch; opcode field is [0:10].
REQ-004 SHALL have port second_inst, input, [0:31]: odd-slot instruction from fetch.
REQ-005 SHALL have port pc_in, input, [0:31]: address of first_inst; second_inst lives at pc_in+4.
REQ-006 SHALL have port branch_taken, input, 1 bit: flush request.
REQ-007 SHALL have port stall, output, 1 bit, combinational: fetch holds its pair and pc on the next edge.
REQ-008 SHALL have ports even_inst and odd_inst, output, [0:31], registered: instruction issued to each pipe.
REQ-009 SHALL have ports even_valid and odd_valid, output, 1 bit, registered: a real (non-NOP) instruction is issued.
REQ-010 SHALL have ports even_pc and odd_pc, output, [0:31], registered: address of each issued instruction.
REQ-011 SHALL have port dual_count, output, [0:31]: count of cycles in which both pipes issued valid instructions.

Function
REQ-012 SHALL classify each instruction with descriptions::pipe_of(inst) as EVEN or ODD; ENOP = opcode 11'b00000000001 (EVEN), ONOP = opcode 11'b01000000001 (ODD); any NOP is invalid.
REQ-013 SHALL implement FSM states PAIR and HOLD.
REQ-014 In PAIR, pair compatible (pipe classes differ, or either instruction is a NOP): issue both in one cycle; routing swaps when first is ODD and second is EVEN; stall=0.
REQ-015 In PAIR, pair conflicting (both EVEN or both ODD, neither a NOP): stall=1; issue first_inst to its pipe with the other pipe set to its NOP (valid=0); capture second_inst and pc_in+4 in a hold register; go to HOLD.
REQ-016 In HOLD: stall=0; issue the held instruction to its pipe with the other pipe set to its NOP; return to PAIR.
REQ-017 Issue latency SHALL be exactly 1 cycle from the sampling edge to the registered outputs.
REQ-018 A pipe with nothing to issue SHALL output ENOP (even) or ONOP (odd) with operand bits 0, valid 0, and pc 0.
REQ-019 branch_taken=1 SHALL win over all other inputs: stall=0 combinationally; next edge outputs both NOPs with valids 0; hold register discarded; state goes to PAIR.
REQ-020 dual_count SHALL increment by 1 on each edge where both issued valids are set, and SHALL wrap from 0xFFFFFFFF to 0.
REQ-021 The pc+4 adder SHALL wrap modulo 2^32.

Reset
REQ-022 On reset=1 at an edge: state PAIR; even_inst {ENOP,21'b0}; odd_inst {ONOP,21'b0}; valids 0; pcs 0; dual_count 0; hold register cleared.
REQ-023 While reset=1, stall SHALL be 0.
REQ-024 Reset asserted in HOLD SHALL drop the held instruction with no issue.

Configuration
REQ-025 Macro DECODE_DEP_CHECK_EN defined: a pair is also conflicting when first_inst is valid and second_inst RA[18:24] or RB[11:17] equals first_inst RT[25:31]; handling per REQ-015.
REQ-026 Macro DECODE_DEP_CHECK_EN undefined: only pipe class decides conflict; no register-field compare logic is built.

Verification
REQ-027 Reset with first=a r3,r1,r2 (EVEN), second=rotqby r5,r6,r7 (ODD) -> first cycle after reset: ENOP/ONOP, valids 0, dual_count 0.
REQ-028 pc_in=0x100, first=rotqby (ODD), second=a (EVEN) -> next cycle: odd_inst=rotqby with odd_pc 0x100, even_inst=a with even_pc 0x104, both valid, dual_count +1, stall never 1.
REQ-029 pc_in=0x200, two EVEN adds -> stall=1 for one cycle; cycle 1: even_pc 0x200 with odd NOP; cycle 2: even_pc 0x204 with odd NOP; dual_count unchanged.
REQ-030 In HOLD, assert branch_taken -> stall 0; next cycle both NOPs, valids 0; held 0x204 never issued.
REQ-031 With DECODE_DEP_CHECK_EN: first=a r3,r1,r2, second=rotqby r5,r3,r7 -> serialized across two cycles; without the macro -> dual-issued in one cycle.
REQ-032 Preload dual_count=0xFFFFFFFF via 2^32-1 dual issues (forced) plus one more -> dual_count=0.
